alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Micro-program sequencer for the 4-bit-operand / 8-bit-accumulator ALU datapath.
//  Holds a small program of {op, operand} words and, on Start, clears the accumulator,
//  then steps each word into the ALU select/operand inputs and pulses the accumulator load.
//  Sits between the switch/key front end and the ALU + accumulator register; Done drives status LEDs.
// PARAMETERS
//  PROG_DEPTH  8   program entries (power of two, 2..16)
//  ADDR_W      3   log2(PROG_DEPTH)
// PORTS
//  Clock     in   1       rising-edge clock
//  Reset     in   1       synchronous, active-high reset
//  Wr_en     in   1       program write strobe (ignored while Busy)
//  Wr_addr   in   ADDR_W  program write address
//  Wr_data   in   7       {op[6:4], operand[3:0]}
//  Start     in   1       run request, sampled in IDLE only
//  Length    in   4       instructions to run; latched on accepted Start
//  Step      in   1       single-step advance (only with SINGLE_STEP_EN)
//  Alu_op    out  3       ALU function select (to ALU Key[3:1])
//  Alu_a     out  4       ALU 4-bit operand A
//  Acc_clear out  1       accumulator synchronous clear, 1 cycle
//  Acc_load  out  1       accumulator load enable, 1 cycle per instruction
//  Pc        out  ADDR_W  current program index
//  Busy      out  1       high from CLEAR through EXEC of last instruction
//  Done      out  1       1-cycle completion pulse
// BEHAVIOUR
//  - Reset: state=IDLE; Alu_op=0, Alu_a=0, Pc=0, Acc_clear=0, Acc_load=0, Busy=0, Done=0.
//    Program memory is NOT cleared by Reset. Reset overrides all other inputs that cycle.
//  - States: IDLE -> CLEAR -> FETCH -> EXEC -> (FETCH | DONE) -> IDLE. Outputs are Moore,
//    registered: Acc_clear=1 only in CLEAR, Acc_load=1 only in EXEC, Done=1 only in DONE,
//    Busy=1 in CLEAR/FETCH/EXEC.
//  - IDLE: Start=1 and Length!=0 -> latch len=min(Length,PROG_DEPTH), Pc<=0, go CLEAR.
//    Start with Length=0 ignored (stay IDLE, no Done).
//  - CLEAR -> FETCH unconditionally.
//  - FETCH: Alu_op<=mem[Pc][6:4], Alu_a<=mem[Pc][3:0]; -> EXEC.
//  - EXEC: Acc_load=1; if Pc==len-1 -> DONE, else Pc<=Pc+1 -> FETCH. Pc never wraps mid-run.
//  - DONE: -> IDLE; Pc, Alu_op, Alu_a hold last values until next run or Reset.
//  - Timing: Start accepted at edge t -> Acc_clear in cycle t+1, Acc_load in cycles
//    t+3, t+5, ..., t+1+2N; Done in cycle t+2+2N (N = len).
//  - Start while Busy/DONE ignored. Wr_en while Busy or DONE ignored (program locked);
//    in IDLE write takes effect at the edge, readable by a Start in the same cycle's next run.
//  - Reset mid-run: next cycle IDLE with all outputs at reset values; no Done pulse.
// CONFIGURATION
//  SINGLE_STEP_EN defined: Step port exists; FETCH->EXEC only in a cycle with Step=1
//    (FETCH holds, Alu_op/Alu_a stable, Busy=1). Step ignored in other states.
//  SINGLE_STEP_EN undefined: no Step port; FETCH->EXEC unconditional.
// TESTING
//  1 Write mem[0]=0x10 (op1,A=0), mem[1]=0x23, mem[2]=0x75; Start,Length=3 at t ->
//    Acc_clear@t+1; Acc_load@t+3/5/7 with (Alu_op,Alu_a)=(1,0),(2,3),(7,5); Done@t+8; Busy 0@t+8.
//  2 Start with Length=0 -> Busy,Done,Acc_clear stay 0; state IDLE.
//  3 Mid-run Start=1 and Wr_en to addr0=0x7F -> ignored; rerun Length=1 gives Alu_op=1,Alu_a=0.
//  4 Reset in EXEC of instruction 2 -> next cycle all outputs 0; rerun Length=3 matches test 1.
//  5 Length=12 -> clamps to 8; Acc_load 8 pulses; Done@t+18; Pc=7 afterward.
//  6 (SINGLE_STEP_EN) Length=2, Step low 5 cycles in FETCH -> no Acc_load; Step pulse ->
//    Acc_load next cycle; Done only after second Step.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Micro-program sequencer for the 4-bit-operand / 8-bit-accumulator ALU datapath.
//   A small program of {op[6:4], operand[3:0]} words is written while idle. Start
//   clears the accumulator, then each word is fetched onto Alu_op/Alu_a and the
//   accumulator load is pulsed once per instruction. Done pulses for one cycle at the end.
//
//   Parameters: PROG_DEPTH (program entries, power of two 2..16), ADDR_W = log2(PROG_DEPTH)
//
//   Ports:
//     Clock, Reset       rising-edge clock, synchronous active-high reset
//     Wr_en/Wr_addr/Wr_data  program write port (only honoured in IDLE)
//     Start, Length      run request and instruction count (sampled in IDLE)
//     Step               single-step advance (only with SINGLE_STEP_EN defined)
//     Alu_op, Alu_a      ALU function select and operand A
//     Acc_clear, Acc_load  accumulator clear / load strobes
//     Pc, Busy, Done     program index, running flag, completion pulse
//
//   Build option: define SINGLE_STEP_EN to add the Step port; FETCH then waits for Step=1.
module alu_sequencer #(
  parameter int PROG_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Wr_en,
  input  logic [ADDR_W-1:0] Wr_addr,
  input  logic [6:0]        Wr_data,
  input  logic              Start,
  input  logic [3:0]        Length,
`ifdef SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic [2:0]        Alu_op,
  output logic [3:0]        Alu_a,
  output logic              Acc_clear,
  output logic              Acc_load,
  output logic [ADDR_W-1:0] Pc,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, EXEC, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [3:0]        alu_a_q, alu_a_d;
  logic              acc_clear_q, acc_clear_d;
  logic              acc_load_q, acc_load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [6:0]        mem_q [PROG_DEPTH];
  logic [6:0]        fetch_word;
  logic [4:0]        clamp_len;
  logic              step_ok;

  // Program memory is deliberately not reset; it is locked whenever a run is in progress.
  always_ff @(posedge Clock) begin
    if (Wr_en && !Reset && state_q == IDLE) begin
      mem_q[Wr_addr] <= Wr_data;
    end
  end

  assign fetch_word = mem_q[pc_q];

`ifdef SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  // Runs longer than the program are clamped so Pc never wraps.
  always_comb begin
    clamp_len = ({1'b0, Length} > 5'(PROG_DEPTH)) ? 5'(PROG_DEPTH) : {1'b0, Length};
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    last_d   = last_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    case (state_q)
      IDLE: begin
        if (Start && Length != 4'd0) begin
          state_d = CLEAR;
          pc_d    = '0;
          last_d  = ADDR_W'(clamp_len - 5'd1);
        end
      end
      CLEAR: state_d = FETCH;
      FETCH: begin
        // Reloaded every FETCH cycle; memory is locked, so values stay stable while stalled.
        alu_op_d = fetch_word[6:4];
        alu_a_d  = fetch_word[3:0];
        if (step_ok) state_d = EXEC;
      end
      EXEC: begin
        if (pc_q == last_q) begin
          state_d = DONE;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Moore outputs are registered from the next state so they line up with the state.
    acc_clear_d = (state_d == CLEAR);
    acc_load_d  = (state_d == EXEC);
    done_d      = (state_d == DONE);
    busy_d      = (state_d == CLEAR) || (state_d == FETCH) || (state_d == EXEC);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      last_q      <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      acc_clear_q <= 1'b0;
      acc_load_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      last_q      <= last_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      acc_clear_q <= acc_clear_d;
      acc_load_q  <= acc_load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Alu_op    = alu_op_q;
  assign Alu_a     = alu_a_q;
  assign Acc_clear = acc_clear_q;
  assign Acc_load  = acc_load_q;
  assign Pc        = pc_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Wr_en = 1'b0;
  logic [2:0] Wr_addr = '0;
  logic [6:0] Wr_data = '0;
  logic       Start = 1'b0;
  logic [3:0] Length = '0;
`ifdef SINGLE_STEP_EN
  logic       Step = 1'b1;
`endif
  logic [2:0] Alu_op;
  logic [3:0] Alu_a;
  logic       Acc_clear;
  logic       Acc_load;
  logic [2:0] Pc;
  logic       Busy;
  logic       Done;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] model_mem [8];
  logic [6:0] exp_q [$];

  alu_sequencer #(.PROG_DEPTH(8), .ADDR_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
    .Start(Start), .Length(Length),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .Alu_op(Alu_op), .Alu_a(Alu_a), .Acc_clear(Acc_clear), .Acc_load(Acc_load),
    .Pc(Pc), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Program writes are issued only while the sequencer is idle, so the model follows them.
  task automatic write_word(input logic [2:0] addr, input logic [6:0] data);
    Wr_en = 1'b1; Wr_addr = addr; Wr_data = data;
    @(negedge Clock);
    Wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  // Full run: start at edge t, then walk cycles t+1 .. t+2+2N checking every strobe.
  // With poke set, a Start and a write to address 0 are thrown at the busy sequencer.
  task automatic do_run(input string nm, input int length, input bit poke);
    int n;
    logic exp_load;
    logic [6:0] exp_w;
    n = (length > 8) ? 8 : length;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(model_mem[i]);
    Start = 1'b1; Length = 4'(length);
    @(negedge Clock);
    Start = 1'b0;
    n_cmp++;
    if ({Acc_clear, Busy, Acc_load, Done} !== 4'b1100) begin
      n_err++; $display("FAIL %s clear_cycle: got clr/busy/load/done=%b want 1100", nm, {Acc_clear, Busy, Acc_load, Done});
    end
    for (int c = 2; c <= 2 + 2 * n; c++) begin
      if (poke && c == 4) begin
        Start = 1'b1; Length = 4'd2; Wr_en = 1'b1; Wr_addr = 3'd0; Wr_data = 7'h7F;
      end
      @(negedge Clock);
      Start = 1'b0; Wr_en = 1'b0;
      exp_load = (c % 2 == 1) && (c <= 1 + 2 * n);
      n_cmp++;
      if (Acc_load !== exp_load) begin
        n_err++; $display("FAIL %s acc_load@t+%0d: got %b want %b", nm, c, Acc_load, exp_load);
      end
      if (Acc_load === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL %s extra_load@t+%0d: got op=%0d a=%0h want none", nm, c, Alu_op, Alu_a);
        end else begin
          exp_w = exp_q.pop_front();
          if ({Alu_op, Alu_a} !== exp_w) begin
            n_err++; $display("FAIL %s operands@t+%0d: got %h want %h", nm, c, {Alu_op, Alu_a}, exp_w);
          end
        end
      end
      n_cmp++;
      if ({Done, Busy, Acc_clear} !== {(c == 2 + 2 * n), (c < 2 + 2 * n), 1'b0}) begin
        n_err++; $display("FAIL %s status@t+%0d: got done/busy/clr=%b%b%b want %b%b0", nm, c,
                          Done, Busy, Acc_clear, (c == 2 + 2 * n), (c < 2 + 2 * n));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s loads_missing: got %0d left want 0", nm, exp_q.size());
    end
    n_cmp++;
    if (Pc !== 3'(n - 1)) begin
      n_err++; $display("FAIL %s final_pc: got %0d want %0d", nm, Pc, n - 1);
    end
    @(negedge Clock);
    n_cmp++;
    if ({Done, Busy} !== 2'b00) begin
      n_err++; $display("FAIL %s back_to_idle: got done/busy=%b want 00", nm, {Done, Busy});
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    n_cmp++;
    if ({Alu_op, Alu_a, Pc, Acc_clear, Acc_load, Busy, Done} !== 14'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {Alu_op, Alu_a, Pc, Acc_clear, Acc_load, Busy, Done});
    end
    Reset = 1'b0;
    @(negedge Clock);
    n_cmp++;
    if ({Busy, Done, Acc_clear} !== 3'b000) begin
      n_err++; $display("FAIL idle_after_reset: got %b want 000", {Busy, Done, Acc_clear});
    end
  endtask

  task automatic test_basic_run();
    write_word(3'd0, 7'h10);
    write_word(3'd1, 7'h23);
    write_word(3'd2, 7'h75);
    do_run("basic", 3, 1'b0);
  endtask

  task automatic test_zero_length();
    Start = 1'b1; Length = 4'd0;
    @(negedge Clock);
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({Busy, Done, Acc_clear, Acc_load} !== 4'b0000) begin
        n_err++; $display("FAIL zero_length[%0d]: got %b want 0000", i, {Busy, Done, Acc_clear, Acc_load});
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_locked_while_busy();
    do_run("locked", 3, 1'b1);
    do_run("rerun_len1", 1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    Start = 1'b1; Length = 4'd3;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    n_cmp++;
    if ({Acc_load, Alu_op, Alu_a} !== {1'b1, 3'd2, 4'd3}) begin
      n_err++; $display("FAIL midrun_exec2: got %h want %h", {Acc_load, Alu_op, Alu_a}, {1'b1, 3'd2, 4'd3});
    end
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    n_cmp++;
    if ({Alu_op, Alu_a, Pc, Acc_clear, Acc_load, Busy, Done} !== 14'd0) begin
      n_err++; $display("FAIL midrun_reset: got %h want 0", {Alu_op, Alu_a, Pc, Acc_clear, Acc_load, Busy, Done});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Done, Busy, Acc_load} !== 3'b000) begin
        n_err++; $display("FAIL midrun_no_done[%0d]: got %b want 000", i, {Done, Busy, Acc_load});
      end
    end
    do_run("after_reset", 3, 1'b0);
  endtask

  task automatic test_clamp();
    logic [6:0] vals [5] = '{7'h14, 7'h36, 7'h5A, 7'h6F, 7'h01};
    for (int i = 0; i < 5; i++) write_word(3'(i + 3), vals[i]);
    do_run("clamp12", 12, 1'b0);
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    Step = 1'b0;
    Start = 1'b1; Length = 4'd2;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Acc_load, Busy, Done} !== 3'b010) begin
        n_err++; $display("FAIL step_hold[%0d]: got load/busy/done=%b want 010", i, {Acc_load, Busy, Done});
      end
    end
    Step = 1'b1;
    @(negedge Clock);
    Step = 1'b0;
    n_cmp++;
    if ({Acc_load, Alu_op, Alu_a} !== {1'b1, model_mem[0]}) begin
      n_err++; $display("FAIL step_load1: got %h want %h", {Acc_load, Alu_op, Alu_a}, {1'b1, model_mem[0]});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      n_cmp++;
      if ({Acc_load, Done} !== 2'b00) begin
        n_err++; $display("FAIL step_hold2[%0d]: got load/done=%b want 00", i, {Acc_load, Done});
      end
    end
    Step = 1'b1;
    @(negedge Clock);
    n_cmp++;
    if ({Acc_load, Alu_op, Alu_a} !== {1'b1, model_mem[1]}) begin
      n_err++; $display("FAIL step_load2: got %h want %h", {Acc_load, Alu_op, Alu_a}, {1'b1, model_mem[1]});
    end
    @(negedge Clock);
    n_cmp++;
    if ({Done, Busy} !== 2'b10) begin
      n_err++; $display("FAIL step_done: got done/busy=%b want 10", {Done, Busy});
    end
    @(negedge Clock);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_run();
    test_zero_length();
    test_locked_while_busy();
    test_reset_mid_run();
    test_clamp();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
